// File: rtl/xor_p_sweep_if.sv
// Control bundle for the xor_p_sweep truth-table engine.
// Master requests sweeps; slave reports status and the captured table.
interface xor_p_sweep_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] table_q;
  logic        pass;
  logic [3:0]  err_idx;

  modport master (
    output start,
    input  busy, done, table_q, pass, err_idx
  );

  modport slave (
    input  start,
    output busy, done, table_q, pass, err_idx
  );
endinterface

// File: rtl/xor_p_sweep.sv
// Exhaustive stimulus/readback sweep for P = W.Y'.Z ^ Y.Z ^ X'.Y.
// Define TT_COMPARE_EN to build in the GOLDEN comparison (pass/err_idx).
module xor_p_sweep #(
  parameter int unsigned SETTLE = 2,
  parameter logic [15:0] GOLDEN = 16'hA684
) (
  input  logic         clk,
  input  logic         rst_n,
  xor_p_sweep_if.slave ctl,
  output logic         W,
  output logic         X,
  output logic         Y,
  output logic         Z,
  input  logic         P
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } state_t;

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);

  state_t      state, state_n;
  logic [3:0]  idx, idx_n;
  logic [7:0]  cnt, cnt_n;
  logic [3:0]  vec, vec_n;
  logic [15:0] tbl, tbl_n;
  logic        busy, busy_n;
  logic        done, done_n;

`ifdef TT_COMPARE_EN
  logic        err, err_n;
  logic        pass, pass_n;
  logic [3:0]  eidx, eidx_n;
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    vec_n   = vec;
    tbl_n   = tbl;
    busy_n  = 1'b0;
    done_n  = 1'b0;
`ifdef TT_COMPARE_EN
    err_n   = err;
    pass_n  = pass;
    eidx_n  = eidx;
`endif
    unique case (state)
      IDLE: begin
        if (ctl.start) begin
          state_n = APPLY;
          idx_n   = 4'd0;
          cnt_n   = 8'd0;
          vec_n   = 4'd0;
          tbl_n   = 16'h0000;
`ifdef TT_COMPARE_EN
          err_n   = 1'b0;
          pass_n  = 1'b0;
          eidx_n  = 4'd0;
`endif
        end
      end
      APPLY: begin
        busy_n = 1'b1;
        if (cnt != SETTLE_C) begin
          cnt_n = cnt + 8'd1;
        end else begin
          tbl_n[idx] = P;
`ifdef TT_COMPARE_EN
          if ((P != GOLDEN[idx]) && !err) begin
            eidx_n = idx;
            err_n  = 1'b1;
          end
`endif
          // vec tracks idx_n so each vector is held exactly SETTLE+1 cycles
          if (idx == 4'hF) begin
            state_n = DONE;
            vec_n   = 4'd0;
          end else begin
            idx_n = idx + 4'd1;
            vec_n = idx + 4'd1;
            cnt_n = 8'd0;
          end
        end
      end
      DONE: begin
        done_n  = 1'b1;
        vec_n   = 4'd0;
        state_n = IDLE;
`ifdef TT_COMPARE_EN
        pass_n  = ~err;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 4'd0;
      cnt   <= 8'd0;
      vec   <= 4'd0;
      tbl   <= 16'h0000;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef TT_COMPARE_EN
      err   <= 1'b0;
      pass  <= 1'b0;
      eidx  <= 4'd0;
`endif
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      vec   <= vec_n;
      tbl   <= tbl_n;
      busy  <= busy_n;
      done  <= done_n;
`ifdef TT_COMPARE_EN
      err   <= err_n;
      pass  <= pass_n;
      eidx  <= eidx_n;
`endif
    end
  end

  assign {W, X, Y, Z}  = vec;
  assign ctl.busy      = busy;
  assign ctl.done      = done;
  assign ctl.table_q   = tbl;

`ifdef TT_COMPARE_EN
  assign ctl.pass      = pass;
  assign ctl.err_idx   = eidx;
`else
  logic unused_golden;
  assign unused_golden = ^GOLDEN;
  assign ctl.pass      = 1'b0;
  assign ctl.err_idx   = 4'd0;
`endif

endmodule

// File: tb/tb_xor_p_sweep.sv
// Bench for xor_p_sweep: SETTLE=2 and SETTLE=0 instances driven by
// a table-based P circuit, checked against an equation-derived model.
module tb_xor_p_sweep;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xor_p_sweep_if if2 ();
  xor_p_sweep_if if0 ();

  logic [15:0] ptab = 16'h0000;
  logic w2, x2, y2, z2, p2;
  logic w0, x0, y0, z0, p0;

  assign p2 = ptab[{w2, x2, y2, z2}];
  assign p0 = ptab[{w0, x0, y0, z0}];

  xor_p_sweep #(.SETTLE(2), .GOLDEN(16'hA684)) u2 (
    .clk(clk), .rst_n(rst_n), .ctl(if2),
    .W(w2), .X(x2), .Y(y2), .Z(z2), .P(p2)
  );

  xor_p_sweep #(.SETTLE(0), .GOLDEN(16'hA684)) u0 (
    .clk(clk), .rst_n(rst_n), .ctl(if0),
    .W(w0), .X(x0), .Y(y0), .Z(z0), .P(p0)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] gold;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: evaluate the Boolean equation for every vector.
  function automatic logic [15:0] eq_table();
    logic [15:0] t;
    logic w, x, y, z;
    t = 16'h0;
    for (int i = 0; i < 16; i++) begin
      w = (i / 8) % 2 == 1;
      x = (i / 4) % 2 == 1;
      y = (i / 2) % 2 == 1;
      z = i % 2 == 1;
      t[i] = (w & ~y & z) ^ (y & z) ^ (~x & y);
    end
    return t;
  endfunction

  function automatic logic [3:0] first_bad(input logic [15:0] t);
    for (int i = 0; i < 16; i++)
      if (t[i] != gold[i]) return 4'(i);
    return 4'd0;
  endfunction

  function automatic logic exp_pass(input logic [15:0] t);
`ifdef TT_COMPARE_EN
    return t == gold;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] exp_eidx(input logic [15:0] t);
`ifdef TT_COMPARE_EN
    return first_bad(t);
`else
    return 4'd0;
`endif
  endfunction

  function automatic logic o_done(input int s);
    return (s == 0) ? if0.done : if2.done;
  endfunction
  function automatic logic o_busy(input int s);
    return (s == 0) ? if0.busy : if2.busy;
  endfunction
  function automatic logic [15:0] o_tbl(input int s);
    return (s == 0) ? if0.table_q : if2.table_q;
  endfunction
  function automatic logic o_pass(input int s);
    return (s == 0) ? if0.pass : if2.pass;
  endfunction
  function automatic logic [3:0] o_eidx(input int s);
    return (s == 0) ? if0.err_idx : if2.err_idx;
  endfunction
  function automatic logic [3:0] o_vec(input int s);
    return (s == 0) ? {w0, x0, y0, z0} : {w2, x2, y2, z2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) if0.start = v;
    else if2.start = v;
  endtask

  // One pulsed sweep; checks latency, vector sequence and results.
  task automatic sweep(input int s, input logic [15:0] tab,
                       input string tag);
    int lat;
    int vbad;
    int per;
    int ev;
    per = s + 1;
    ptab = tab;
    set_start(s, 1'b1);
    tick();
    set_start(s, 1'b0);
    lat = 0;
    vbad = 0;
    while (!o_done(s) && lat < 300) begin
      ev = (lat < 16 * per) ? lat / per : 0;
      if (o_vec(s) !== 4'(ev)) vbad++;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 16 * per + 1);
    chk({tag, "_vec_seq_errs"}, vbad, 0);
    chk({tag, "_busy_at_done"}, o_busy(s), 1'b0);
    chk({tag, "_table"}, o_tbl(s), tab);
    chk({tag, "_pass"}, o_pass(s), exp_pass(tab));
    chk({tag, "_err_idx"}, o_eidx(s), exp_eidx(tab));
    tick();
    chk({tag, "_done_one_cycle"}, o_done(s), 1'b0);
    tick();
    chk({tag, "_table_hold"}, o_tbl(s), tab);
  endtask

  initial begin
    int t;
    int nd;
    int t1;
    int t2;
    logic b1;
    logic b2;
    logic [15:0] rt;

    if2.start = 1'b0;
    if0.start = 1'b0;
    gold = eq_table();
    rst_n = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 3; s += 2) begin
      chk("rst_busy", o_busy(s), 1'b0);
      chk("rst_done", o_done(s), 1'b0);
      chk("rst_vec", o_vec(s), 4'd0);
      chk("rst_table", o_tbl(s), 16'h0);
      chk("rst_pass", o_pass(s), 1'b0);
      chk("rst_err_idx", o_eidx(s), 4'd0);
    end
    rst_n = 1'b1;
    tick();

    sweep(2, gold, "good_s2");
    sweep(2, 16'h0000, "stuck0_s2");
    sweep(2, 16'hFFFF, "stuck1_s2");
    sweep(0, gold, "good_s0");
    sweep(0, 16'h0000, "stuck0_s0");

    for (int r = 0; r < 4; r++) begin
      rt = 16'($urandom);
      sweep(2, rt, "rand_s2");
      sweep(0, rt, "rand_s0");
    end

    // Reset while the sweep is on vector 5
    ptab = gold;
    set_start(2, 1'b1);
    tick();
    set_start(2, 1'b0);
    t = 0;
    while (o_vec(2) !== 4'd5 && t < 100) begin
      tick();
      t++;
    end
    chk("mid_reach_vec5", (t < 100), 1'b1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", o_busy(2), 1'b0);
    chk("mid_rst_vec", o_vec(2), 4'd0);
    chk("mid_rst_table", o_tbl(2), 16'h0);
    rst_n = 1'b1;
    tick();
    sweep(2, gold, "after_rst");

    // Start pulsed again while busy must be ignored
    set_start(2, 1'b1);
    tick();
    set_start(2, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    set_start(2, 1'b1);
    tick();
    set_start(2, 1'b0);
    nd = 0;
    for (int i = 0; i < 100; i++) begin
      if (o_done(2)) nd++;
      tick();
    end
    chk("ignore_done_count", nd, 1);
    chk("ignore_idle_busy", o_busy(2), 1'b0);

    // Start held high: back-to-back sweeps, one idle cycle apart
    set_start(2, 1'b1);
    nd = 0;
    t = 0;
    t1 = 0;
    t2 = 0;
    b1 = 1'b1;
    b2 = 1'b0;
    while (nd < 2 && t < 300) begin
      tick();
      t++;
      if (nd == 1 && t == t1 + 1) b1 = o_busy(2);
      if (nd == 1 && t == t1 + 2) b2 = o_busy(2);
      if (o_done(2)) begin
        nd++;
        if (nd == 1) t1 = t;
        else t2 = t;
      end
    end
    set_start(2, 1'b0);
    chk("held_done_count", nd, 2);
    chk("held_gap", t2 - t1, 50);
    chk("held_idle_gap", b1, 1'b0);
    chk("held_busy_again", b2, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("held_stop_busy", o_busy(2), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
